// File: rtl/dev_timing_vga.sv
// VGA scan timing generator: pixel tick at sys_clk/2, frame-buffer address issue and a two-tick
// colour/sync pipeline. Optional VGA_TESTPAT_EN adds a test_mode input that replaces memory data with colour bars.
module dev_timing_vga #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        en,
`ifdef VGA_TESTPAT_EN
  input  logic        test_mode,
`endif
  output logic [12:0] rd_adrs,
  input  logic [15:0] rd_data,
  output logic [9:0]  oVGA_R,
  output logic [9:0]  oVGA_G,
  output logic [9:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK,
  output logic        oVGA_SYNC,
  output logic        oVGA_CLK,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HB      = $clog2(H_TOTAL);
  localparam int VB      = $clog2(V_TOTAL);
  localparam int HVB     = (HB > VB) ? HB : VB;
  // At least 10 bits so the colour-bar index h_cnt[9:7] always exists.
  localparam int CW      = (HVB > 10) ? HVB : 10;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [12:0]   ADR_STRIDE = 13'(H_ACTIVE / 8);

  logic          r_pix_en;
  logic          r_vga_clk;
  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [12:0]   r_adrs;
  logic          r_hs_p1;
  logic          r_vs_p1;
  logic          r_act_p1;
  logic [9:0]    r_red;
  logic [9:0]    r_grn;
  logic [9:0]    r_blu;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
`ifdef VGA_TESTPAT_EN
  logic [2:0]    r_bar_p1;
`endif

  logic          w_hs_raw;
  logic          w_vs_raw;
  logic          w_act_raw;
  logic [12:0]   w_adrs;
  logic [9:0]    w_red;
  logic [9:0]    w_grn;
  logic [9:0]    w_blu;
  logic          w_unused_msb;

  assign w_hs_raw  = (r_h_cnt >= HS_START) && (r_h_cnt <= HS_END);
  assign w_vs_raw  = (r_v_cnt >= VS_START) && (r_v_cnt <= VS_END);
  assign w_act_raw = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  // One frame-buffer word covers an 8x8 pixel block.
  assign w_adrs    = 13'(r_v_cnt >> 3) * ADR_STRIDE + 13'(r_h_cnt >> 3);
  assign w_unused_msb = rd_data[15];

  always_comb begin
    w_red = {rd_data[14:10], rd_data[14:10]};
    w_grn = {rd_data[9:5],   rd_data[9:5]};
    w_blu = {rd_data[4:0],   rd_data[4:0]};
`ifdef VGA_TESTPAT_EN
    if (test_mode) begin
      w_red = {10{r_bar_p1[2]}};
      w_grn = {10{r_bar_p1[1]}};
      w_blu = {10{r_bar_p1[0]}};
    end
`endif
  end

  // Stage 1 issues rd_adrs; rd_data settles one sys_clk later, and stage 2
  // samples it on the next pixel tick together with the delayed sync/blank.
  always_ff @(posedge sys_clk) begin
    if (rst || !en) begin
      r_pix_en  <= 1'b0;
      r_vga_clk <= 1'b1;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_adrs    <= '0;
      r_hs_p1   <= 1'b1;
      r_vs_p1   <= 1'b1;
      r_act_p1  <= 1'b0;
      r_red     <= '0;
      r_grn     <= '0;
      r_blu     <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank   <= 1'b0;
`ifdef VGA_TESTPAT_EN
      r_bar_p1  <= '0;
`endif
    end else begin
      r_pix_en  <= ~r_pix_en;
      r_vga_clk <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_ONE;
        end else begin
          r_h_cnt <= r_h_cnt + CNT_ONE;
        end
        if (w_act_raw) r_adrs <= w_adrs;
        r_hs_p1  <= ~w_hs_raw;
        r_vs_p1  <= ~w_vs_raw;
        r_act_p1 <= w_act_raw;
`ifdef VGA_TESTPAT_EN
        r_bar_p1 <= r_h_cnt[9:7];
`endif
        r_red   <= r_act_p1 ? w_red : '0;
        r_grn   <= r_act_p1 ? w_grn : '0;
        r_blu   <= r_act_p1 ? w_blu : '0;
        r_hs    <= r_hs_p1;
        r_vs    <= r_vs_p1;
        r_blank <= r_act_p1;
      end
    end
  end

  assign rd_adrs     = r_adrs;
  assign oVGA_R      = r_red;
  assign oVGA_G      = r_grn;
  assign oVGA_B      = r_blu;
  assign oVGA_HS     = r_hs;
  assign oVGA_VS     = r_vs;
  assign oVGA_BLANK  = r_blank;
  assign oVGA_SYNC   = 1'b0;
  assign oVGA_CLK    = r_vga_clk;
  assign frame_start = r_pix_en && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: tb/tb_dev_timing_vga.sv
// Bench for dev_timing_vga: a full-size instance and a reduced-timing instance run in lockstep
// against a position-based reference model. Define VGA_TESTPAT_EN to also exercise test_mode.
module tb_dev_timing_vga;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic tm_cur = 1'b0;

  logic [15:0] mem [8192];

  logic [12:0] adrs_a, adrs_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [9:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, bl_a, sy_a, ck_a, fs_a;
  logic        hs_b, vs_b, bl_b, sy_b, ck_b, fs_b;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  always #10 clk = ~clk;

  // Frame-buffer model: word appears one sys_clk after the address.
  always @(posedge clk) begin
    rd_data_a <= mem[adrs_a];
    rd_data_b <= mem[adrs_b];
  end

  dev_timing_vga u_dut_a (
    .sys_clk(clk), .rst(rst), .en(en),
`ifdef VGA_TESTPAT_EN
    .test_mode(tm_cur),
`endif
    .rd_adrs(adrs_a), .rd_data(rd_data_a),
    .oVGA_R(r_a), .oVGA_G(g_a), .oVGA_B(b_a),
    .oVGA_HS(hs_a), .oVGA_VS(vs_a), .oVGA_BLANK(bl_a), .oVGA_SYNC(sy_a),
    .oVGA_CLK(ck_a), .frame_start(fs_a)
  );

  dev_timing_vga #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_b (
    .sys_clk(clk), .rst(rst), .en(en),
`ifdef VGA_TESTPAT_EN
    .test_mode(tm_cur),
`endif
    .rd_adrs(adrs_b), .rd_data(rd_data_b),
    .oVGA_R(r_b), .oVGA_G(g_b), .oVGA_B(b_b),
    .oVGA_HS(hs_b), .oVGA_VS(vs_b), .oVGA_BLANK(bl_b), .oVGA_SYNC(sy_b),
    .oVGA_CLK(ck_b), .frame_start(fs_b)
  );

  // Expected outputs after kk rising edges with en=1 (kk=0: held in reset).
  // Pixel tick n happens every second edge; outputs show pixel n-2, the address the last issued active pixel.
  function automatic logic [48:0] model(input int kk, input int ha, input int hfp, input int hsy,
                                        input int hbp, input int va, input int vfp, input int vsy,
                                        input int vbp, input bit tm);
    int ht, vt, n, q, p, h, v, lh, lv;
    logic [12:0] ad;
    logic [15:0] w;
    logic [9:0]  rr, gg, bb;
    logic [2:0]  bar;
    logic        hs, vs, bl, ck, fs;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    n  = kk / 2;
    ad = '0;
    if (n > 0) begin
      q  = (n - 1) % (ht * vt);
      h  = q % ht;
      v  = q / ht;
      lv = (v < va) ? v : va - 1;
      lh = (v < va && h < ha) ? h : ha - 1;
      ad = 13'((lv / 8) * (ha / 8) + lh / 8);
    end
    hs = 1'b1; vs = 1'b1; bl = 1'b0; rr = '0; gg = '0; bb = '0;
    p = n - 2;
    if (p >= 0) begin
      q  = p % (ht * vt);
      h  = q % ht;
      v  = q / ht;
      hs = !(h >= ha + hfp && h < ha + hfp + hsy);
      vs = !(v >= va + vfp && v < va + vfp + vsy);
      bl = (h < ha) && (v < va);
      if (bl && tm) begin
        bar = 3'((h / 128) % 8);
        rr = {10{bar[2]}}; gg = {10{bar[1]}}; bb = {10{bar[0]}};
      end else if (bl) begin
        w  = mem[(v / 8) * (ha / 8) + h / 8];
        rr = {w[14:10], w[14:10]}; gg = {w[9:5], w[9:5]}; bb = {w[4:0], w[4:0]};
      end
    end
    ck = (kk == 0) ? 1'b1 : (kk % 2 == 1);
    fs = (kk % 2 == 1) && (n % (ht * vt) == 0);
    return {ad, rr, gg, bb, hs, vs, bl, 1'b0, ck, fs};
  endfunction

  function automatic logic [97:0] exp_v(input int kk);
    return {model(kk, 640, 16, 96, 48, 480, 10, 2, 33, tm_cur),
            model(kk, 32, 4, 8, 4, 24, 2, 2, 3, tm_cur)};
  endfunction

  function automatic logic [97:0] act();
    return {adrs_a, r_a, g_a, b_a, hs_a, vs_a, bl_a, sy_a, ck_a, fs_a,
            adrs_b, r_b, g_b, b_b, hs_b, vs_b, bl_b, sy_b, ck_b, fs_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst || !en) k = 0;
    else k++;
    @(negedge clk);
  endtask

  task automatic restart();
    rst = 1'b0;
    en  = 1'b0;
    tick();
    en  = 1'b1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (act() !== exp_v(0)) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, act(), exp_v(0));
      end
    end
    total++;
    if ({adrs_a, r_a, hs_a, vs_a, bl_a, ck_a, fs_a} !== {13'd0, 10'd0, 5'b11010}) begin
      bad++;
      $display("FAIL reset_literal got=%b exp=%b", {adrs_a, r_a, hs_a, vs_a, bl_a, ck_a, fs_a},
               {13'd0, 10'd0, 5'b11010});
    end
  endtask

  task automatic test_line_timing();
    int f1, f2, low;
    logic ph;
    f1 = -1; f2 = -1; low = 0; ph = 1'b1;
    fill_random();
    restart();
    for (int i = 0; i < 3500; i++) begin
      tick();
      total++;
      if (act() !== exp_v(k)) begin
        bad++;
        $display("FAIL line_stream k=%0d got=%h exp=%h", k, act(), exp_v(k));
      end
      if (k == 1) begin
        total++;
        if (fs_a !== 1'b1) begin
          bad++;
          $display("FAIL first_frame_start got=%b exp=1", fs_a);
        end
      end
      if (ph && !hs_a) begin
        if (f1 < 0) f1 = k;
        else if (f2 < 0) f2 = k;
      end
      if (f1 >= 0 && f2 < 0 && !hs_a) low++;
      ph = hs_a;
    end
    total++;
    if (f2 - f1 != 1600) begin
      bad++;
      $display("FAIL hs_period got=%0d exp=1600", f2 - f1);
    end
    total++;
    if (low != 192) begin
      bad++;
      $display("FAIL hs_low got=%0d exp=192", low);
    end
  endtask

  task automatic test_frame();
    int f1, f2, low, blk, fsn, amax_a, amax_b;
    logic pv;
    f1 = -1; f2 = -1; low = 0; blk = 0; fsn = 0; amax_a = 0; amax_b = 0; pv = 1'b1;
    fill_random();
    restart();
    for (int i = 0; i < 9028; i++) begin
      tick();
      total++;
      if (act() !== exp_v(k)) begin
        bad++;
        $display("FAIL frame_stream k=%0d got=%h exp=%h", k, act(), exp_v(k));
      end
      if (pv && !vs_b) begin
        if (f1 < 0) f1 = k;
        else if (f2 < 0) f2 = k;
      end
      if (f1 >= 0 && f2 < 0) begin
        if (!vs_b) low++;
        if (bl_b && ck_b) blk++;
      end
      pv = vs_b;
      if (fs_b) fsn++;
      if (int'(adrs_a) > amax_a) amax_a = int'(adrs_a);
      if (int'(adrs_b) > amax_b) amax_b = int'(adrs_b);
    end
    total++;
    if (f2 - f1 != 2976) begin
      bad++;
      $display("FAIL vs_period got=%0d exp=2976", f2 - f1);
    end
    total++;
    if (low != 192) begin
      bad++;
      $display("FAIL vs_low got=%0d exp=192", low);
    end
    total++;
    if (blk != 768) begin
      bad++;
      $display("FAIL blank_ticks got=%0d exp=768", blk);
    end
    total++;
    if (fsn != 4) begin
      bad++;
      $display("FAIL frame_start_count got=%0d exp=4", fsn);
    end
    total++;
    if (amax_b != 11 || amax_a > 4799) begin
      bad++;
      $display("FAIL adrs_range got_b=%0d exp_b=11 got_a=%0d max_a=4799", amax_b, amax_a);
    end
  endtask

  task automatic test_addr();
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    mem[81] = 16'h7FFF;
    mem[82] = 16'h0000;
    restart();
    for (int i = 0; i < 12840; i++) begin
      tick();
      total++;
      if (act() !== exp_v(k)) begin
        bad++;
        $display("FAIL addr_stream k=%0d got=%h exp=%h", k, act(), exp_v(k));
      end
      if (k == 12818) begin
        total++;
        if (adrs_a !== 13'd81) begin
          bad++;
          $display("FAIL adrs_8_8 got=%0d exp=81", adrs_a);
        end
      end
      if (k == 12820) begin
        total++;
        if ({r_a, g_a, b_a, bl_a} !== {30'h3FFF_FFFF, 1'b1}) begin
          bad++;
          $display("FAIL rgb_7fff got=%h exp=%h", {r_a, g_a, b_a, bl_a}, {30'h3FFF_FFFF, 1'b1});
        end
      end
      if (k == 12836) begin
        total++;
        if ({r_a, g_a, b_a, bl_a} !== {30'h0, 1'b1}) begin
          bad++;
          $display("FAIL rgb_0000 got=%h exp=%h", {r_a, g_a, b_a, bl_a}, {30'h0, 1'b1});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int run;
    fill_random();
    restart();
    run = $urandom_range(1000, 5000);
    for (int i = 0; i < run; i++) begin
      tick();
      total++;
      if (act() !== exp_v(k)) begin
        bad++;
        $display("FAIL pre_reset_stream k=%0d got=%h exp=%h", k, act(), exp_v(k));
      end
    end
    rst = 1'b1;
    tick();
    total++;
    if (act() !== exp_v(0)) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=%h", act(), exp_v(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      tick();
      total++;
      if (act() !== exp_v(k)) begin
        bad++;
        $display("FAIL post_reset_stream k=%0d got=%h exp=%h", k, act(), exp_v(k));
      end
      if (k == 1) begin
        total++;
        if ({fs_a, fs_b} !== 2'b11) begin
          bad++;
          $display("FAIL post_reset_frame_start got=%b exp=11", {fs_a, fs_b});
        end
      end
    end
  endtask

  task automatic test_en_toggle();
    int run, off;
    for (int t = 0; t < 8; t++) begin
      run = $urandom_range(50, 400);
      for (int i = 0; i < run; i++) begin
        tick();
        total++;
        if (act() !== exp_v(k)) begin
          bad++;
          $display("FAIL en_run k=%0d got=%h exp=%h", k, act(), exp_v(k));
        end
      end
      en  = 1'b0;
      off = $urandom_range(1, 5);
      for (int i = 0; i < off; i++) begin
        tick();
        total++;
        if (act() !== exp_v(0)) begin
          bad++;
          $display("FAIL en_low got=%h exp=%h", act(), exp_v(0));
        end
      end
      en = 1'b1;
    end
  endtask

`ifdef VGA_TESTPAT_EN
  task automatic test_testpat();
    fill_random();
    rst = 1'b0;
    en  = 1'b0;
    tm_cur = 1'b1;
    tick();
    en = 1'b1;
    for (int i = 0; i < 1400; i++) begin
      tick();
      total++;
      if (act() !== exp_v(k)) begin
        bad++;
        $display("FAIL testpat_stream k=%0d got=%h exp=%h", k, act(), exp_v(k));
      end
      if (k == 24) begin
        total++;
        if ({r_a, g_a, b_a} !== 30'h0) begin
          bad++;
          $display("FAIL testpat_bar0 got=%h exp=0", {r_a, g_a, b_a});
        end
      end
      if (k == 1044) begin
        total++;
        if ({r_a, g_a, b_a} !== {10'h3FF, 10'h0, 10'h0}) begin
          bad++;
          $display("FAIL testpat_bar4 got=%h exp=%h", {r_a, g_a, b_a}, {10'h3FF, 10'h0, 10'h0});
        end
      end
    end
    en = 1'b0;
    tick();
    tm_cur = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_line_timing();
    test_frame();
    test_addr();
    test_mid_reset();
    test_en_toggle();
`ifdef VGA_TESTPAT_EN
    test_testpat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
